// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target with glitch-filtered inputs and a pointer-addressed register file
module i2c_target_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h2A,
  parameter int         NUM_REGS   = 16,
  parameter int         FILTER_LEN = 3,
  parameter int         PTR_W      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i2c_scl,
  inout  wire              i2c_sda,
  output logic             reg_wr_strobe,
  output logic [PTR_W-1:0] reg_wr_index,
  output logic [7:0]       reg_wr_data,
  input  logic [PTR_W-1:0] host_rd_index,
  output logic [7:0]       host_rd_data,
  output logic             busy,
  output logic             addr_match
);

  localparam logic [2:0]       FILT_LAST = 3'(FILTER_LEN - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_PTR, S_WR_PTR_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  logic [1:0]       scl_sync, sda_sync;
  logic [2:0]       scl_cnt, sda_cnt;
  logic             scl_f, sda_f;
  logic             scl_rise, scl_fall, sda_rise, sda_fall;
  logic             start_cond, stop_cond;

  state_t           state;
  logic [7:0]       regs [NUM_REGS];
  logic [7:0]       shreg;
  logic [7:0]       rx_byte;
  logic [3:0]       bit_cnt;
  logic [PTR_W-1:0] ptr;
  logic             sda_low, ack_hold, rw;

  assign i2c_sda      = sda_low ? 1'b0 : 1'bz;
  assign host_rd_data = regs[host_rd_index];
  assign rx_byte      = {shreg[6:0], sda_f};
  assign start_cond   = sda_fall & scl_f;
  assign stop_cond    = sda_rise & scl_f;

  // Filtered level follows the synchronised input only after FILTER_LEN equal samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_cnt  <= 3'd0;
      sda_cnt  <= 3'd0;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      sda_rise <= 1'b0;
      sda_fall <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[0], i2c_scl};
      sda_sync <= {sda_sync[0], i2c_sda};
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      sda_rise <= 1'b0;
      sda_fall <= 1'b0;
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= 3'd0;
      end else if (scl_cnt == FILT_LAST) begin
        scl_cnt  <= 3'd0;
        scl_f    <= scl_sync[1];
        scl_rise <= scl_sync[1];
        scl_fall <= ~scl_sync[1];
      end else begin
        scl_cnt <= scl_cnt + 3'd1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= 3'd0;
      end else if (sda_cnt == FILT_LAST) begin
        sda_cnt  <= 3'd0;
        sda_f    <= sda_sync[1];
        sda_rise <= sda_sync[1];
        sda_fall <= ~sda_sync[1];
      end else begin
        sda_cnt <= sda_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      shreg         <= 8'h00;
      bit_cnt       <= 4'd0;
      ptr           <= '0;
      sda_low       <= 1'b0;
      ack_hold      <= 1'b0;
      rw            <= 1'b0;
      busy          <= 1'b0;
      addr_match    <= 1'b0;
      reg_wr_strobe <= 1'b0;
      reg_wr_index  <= '0;
      reg_wr_data   <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      addr_match    <= 1'b0;
      reg_wr_strobe <= 1'b0;
      if (start_cond) begin
        state   <= S_ADDR;
        bit_cnt <= 4'd0;
        sda_low <= 1'b0;
        busy    <= 1'b0;
      end else if (stop_cond) begin
        state   <= S_IDLE;
        sda_low <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_WR_PTR, S_WR_DATA: begin
            if (scl_rise) begin
              shreg <= rx_byte;
              if (bit_cnt != 4'd7) begin
                bit_cnt <= bit_cnt + 4'd1;
              end else begin
                bit_cnt  <= 4'd0;
                ack_hold <= 1'b0;
                if (state == S_ADDR) begin
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                    state      <= S_ADDR_ACK;
                    addr_match <= 1'b1;
                    rw         <= rx_byte[0];
                  end else begin
                    state <= S_IGNORE;
                  end
                end else if (state == S_WR_PTR) begin
                  if ({1'b0, rx_byte} < 9'(NUM_REGS)) begin
                    ptr   <= rx_byte[PTR_W-1:0];
                    state <= S_WR_PTR_ACK;
                  end else begin
                    state <= S_IGNORE;
                  end
                end else begin
                  regs[ptr]     <= rx_byte;
                  reg_wr_strobe <= 1'b1;
                  reg_wr_index  <= ptr;
                  reg_wr_data   <= rx_byte;
                  ptr           <= ptr + PTR_ONE;
                  state         <= S_WR_ACK;
                end
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_hold) begin
                sda_low  <= 1'b1;
                ack_hold <= 1'b1;
                busy     <= 1'b1;
              end else if (rw) begin
                // The ACK-ending fall also puts the first read bit on the bus.
                state   <= S_RD_DATA;
                sda_low <= ~regs[ptr][7];
                shreg   <= {regs[ptr][6:0], 1'b0};
                bit_cnt <= 4'd1;
              end else begin
                state   <= S_WR_PTR;
                sda_low <= 1'b0;
              end
            end
          end
          S_WR_PTR_ACK, S_WR_ACK: begin
            if (scl_fall) begin
              if (!ack_hold) begin
                sda_low  <= 1'b1;
                ack_hold <= 1'b1;
              end else begin
                sda_low <= 1'b0;
                state   <= S_WR_DATA;
              end
            end
          end
          S_RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd0) begin
                sda_low <= ~regs[ptr][7];
                shreg   <= {regs[ptr][6:0], 1'b0};
                bit_cnt <= 4'd1;
              end else if (bit_cnt == 4'd8) begin
                sda_low <= 1'b0;
                state   <= S_RD_ACK;
              end else begin
                sda_low <= ~shreg[7];
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              ptr     <= ptr + PTR_ONE;
              bit_cnt <= 4'd0;
              state   <= sda_f ? S_IGNORE : S_RD_DATA;
            end
          end
          default: sda_low <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
Parametrised I2C target (peripheral) that samples SCL/SDA with a system clock and exposes an internal register file.
- Supports START, repeated START and STOP detection.
- Supports addressed write with register pointer and auto-increment, and addressed read with master ACK/NACK handling.
- Glitch-filters SCL/SDA.
- Sits between the board I2C bus and local control logic, which observes writes and reads registers through a host port.

Parameters:
SLAVE_ADDR, 7'h2A, 7-bit target address matched against first byte.
NUM_REGS, 16, register-file depth; power of two, 2..256.
FILTER_LEN, 3, consecutive identical samples required before filtered SCL/SDA change (1..8).
PTR_W, $clog2(NUM_REGS), derived pointer width; not overridden.

Ports:
clk  in  1  system clock; must be at least 16x SCL frequency.
rst  in  1  reset, synchronous, active-high.
i2c_scl  in  1  bus clock (target never stretches).
i2c_sda  inout  1  open-drain. Driven 0 when pulling low, else 1'bz.
reg_wr_strobe  out  1  one-clk pulse when an I2C data byte is committed.
reg_wr_index  out  PTR_W  register index of committed byte.
reg_wr_data  out  8  committed byte.
host_rd_index  in  PTR_W  host read index.
host_rd_data  out  8  combinational read of regfile[host_rd_index].
busy  out  1  high from address-matched ACK until STOP/START/reset.
addr_match  out  1  one-clk pulse when address byte matches.

Behaviour:
Reset:
- On rst high at a clk edge: state IDLE, all registers 0, pointer 0, SDA released.
- Outputs reg_wr_strobe, reg_wr_index, reg_wr_data, busy and addr_match are 0.
- Reset mid-transaction releases SDA on the first clk edge with rst high.

Input conditioning:
- Two-flop synchroniser per line, then filter; filtered value changes only after FILTER_LEN equal samples.
- Rise/fall flags are derived from the filtered values; input-to-flag latency is 2+FILTER_LEN clks.

Bus conditions:
- START = filtered SDA fall while SCL high. STOP = SDA rise while SCL high.
- Both act from any state and take priority over bit processing in the same clk.
- START (incl. repeated) -> ADDR, bit count 0, SDA released, pointer preserved.
- STOP -> IDLE, SDA released, busy 0.

Bit timing:
- Receive bits are sampled on filtered SCL rise, MSB first.
- Target SDA drive changes only on filtered SCL fall.

States:
- IDLE: wait for START.
- ADDR: shift 8 bits (addr[6:0], R/W).
  - On 8th rise: match -> ADDR_ACK and pulse addr_match.
  - Mismatch -> IGNORE; never drive.
- ADDR_ACK: next SCL fall drives 0; following fall releases. Then R/W=0 -> WR_PTR; R/W=1 -> RD_DATA, loading regfile[ptr] and driving bit7 on that same fall.
- WR_PTR: shift 8 bits.
  - Value < NUM_REGS -> ptr=value, ACK via WR_PTR_ACK, then WR_DATA.
  - Value >= NUM_REGS -> no ACK (SDA released), go IGNORE.
- WR_DATA: shift 8 bits.
  - On the 8th rise: write regfile[ptr]; on the next clk pulse reg_wr_strobe with reg_wr_index=ptr and reg_wr_data=byte.
  - Then ptr = (ptr+1) mod NUM_REGS and go to WR_ACK.
  - WR_ACK drives 0 for one SCL period, then returns to WR_DATA.
- RD_DATA: shift out on each fall. After the 8th bit's fall-to-fall period, release SDA and go to RD_ACK.
- RD_ACK: sample master bit on rise.
  - 0 -> ptr=(ptr+1) mod NUM_REGS, load next byte, RD_DATA.
  - 1 (NACK) -> ptr incremented, IGNORE.
- IGNORE: SDA released; leave only on START/STOP.

Additional rules:
- Pointer wraps NUM_REGS-1 -> 0 in both write and read.
- Same-clk I2C write and host read of one index: host_rd_data shows the old value that clk, the new value from the next.
- Partial byte cut by START/STOP is discarded, with no strobe and no pointer change.
- busy is high from the addr-match ACK drive until leaving via STOP/START/reset. A repeated START clears busy until the next match.

Test Plan:
- Glitch: single-clk SCL high pulse while SDA toggles -> no START/bit detected, state IDLE, SDA never driven.
- Write: START, 0x54, 0x03, 0xA5, 0x5A, STOP -> four ACKs (SDA=0 in 9th clocks); strobes (3,0xA5) then (4,0x5A); host_rd_data at index 3 = 0xA5, at index 4 = 0x5A; busy 0 after STOP.
- Read with repeated START: START, 0x54, 0x03, Sr, 0x55, master ACK then NACK, STOP -> SDA bits 0xA5 then 0x5A; SDA released after NACK; no reg_wr_strobe.
- Address mismatch: START, 0x50, 0x11, STOP -> SDA never driven, addr_match/busy stay 0, no strobes.
- Wrap and bad pointer: write ptr 0x0F, data 0x11,0x22 -> index15=0x11, index0=0x22. Write ptr 0x20 -> NACK, following 0x77 ignored, registers unchanged.
- Reset mid-read while target drives SDA=0 -> SDA released the next clk, all registers 0, busy 0, next START processed normally.
